// File: rtl/mem_stage.sv
// mem_stage: EX->MEM pipeline register and data-memory access stage.
// Drives a req/addr_ok/data_ok bus and holds the front end until the transfer ends.
module mem_stage #(
  parameter int WB_CTRL_W = 13
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          inst_i,
  input  logic                 valid_i,
  input  logic [4:0]           mem_ctrl_i,
  input  logic [WB_CTRL_W-1:0] wb_ctrl_i,
  input  logic [31:0]          ALUOut_i,
  input  logic [31:0]          wdata_i,
  input  logic [4:0]           dest_i,
  output logic                 stall_o,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [1:0]           data_size,
  output logic [31:0]          data_addr,
  output logic [3:0]           data_wstrb,
  output logic [31:0]          data_wdata,
  input  logic                 data_addr_ok,
  input  logic [31:0]          data_rdata,
  input  logic                 data_data_ok,
  output logic [31:0]          pc_o,
  output logic [31:0]          inst_o,
  output logic [WB_CTRL_W-1:0] wb_ctrl_o,
  output logic [31:0]          rdata_o,
  output logic [31:0]          ALUOut_o,
  output logic [4:0]           db_dest_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0]          pc_q;
  logic [31:0]          inst_q;
  logic [31:0]          alu_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_raw;
  logic                 valid_q;
  logic [4:0]           mem_ctrl_q;
  logic [WB_CTRL_W-1:0] wb_ctrl_q;
  logic [4:0]           dest_q;

  logic       is_mem_i;
  logic       xfer_done;
  logic [1:0] a;
  logic [1:0] size_q;
  logic       uns_q;
  logic       rd_q;
  logic       wr_q;
  logic       sz_b;
  logic       sz_h;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        ext;

  assign stall_o   = (state == REQ) | (state == WAIT);
  assign is_mem_i  = valid_i & (mem_ctrl_i[0] | mem_ctrl_i[1]);
  assign xfer_done = data_data_ok &
                     (((state == REQ) & data_addr_ok) | (state == WAIT));

  assign a      = alu_q[1:0];
  assign size_q = mem_ctrl_q[3:2];
  assign uns_q  = mem_ctrl_q[4];
  assign wr_q   = mem_ctrl_q[1];
  // Read+write together behaves as a store
  assign rd_q   = mem_ctrl_q[0] & ~mem_ctrl_q[1];
  assign sz_b   = (size_q == 2'd0);
  assign sz_h   = (size_q == 2'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q       <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
      alu_q      <= '0;
      wdata_q    <= '0;
      dest_q     <= '0;
    end else if (!stall_o) begin
      pc_q       <= pc_i;
      inst_q     <= inst_i;
      valid_q    <= valid_i;
      mem_ctrl_q <= valid_i ? mem_ctrl_i : 5'd0;
      wb_ctrl_q  <= wb_ctrl_i;
      alu_q      <= ALUOut_i;
      wdata_q    <= wdata_i;
      dest_q     <= dest_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_raw <= '0;
    end else if (xfer_done) begin
      rdata_raw <= data_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: state_nx = is_mem_i ? REQ : IDLE;
      REQ: begin
        if (data_addr_ok) begin
          state_nx = data_data_ok ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (data_data_ok) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign data_req  = (state == REQ);
  assign data_wr   = wr_q;
  assign data_addr = alu_q;
  assign data_size = size_q[1] ? 2'd2 : size_q;

  always_comb begin
    data_wstrb = 4'h0;
    data_wdata = wdata_q;
    unique case (1'b1)
      sz_b: begin
        data_wdata = {4{wdata_q[7:0]}};
        if (wr_q) data_wstrb = 4'b0001 << a;
      end
      sz_h: begin
        data_wdata = {2{wdata_q[15:0]}};
        if (wr_q) data_wstrb = a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (wr_q) data_wstrb = 4'hF;
      end
    endcase
  end

  assign byte_sel = rdata_raw[{a, 3'b000} +: 8];
  assign half_sel = a[1] ? rdata_raw[31:16] : rdata_raw[15:0];
  assign ext      = ~uns_q & (sz_b ? byte_sel[7] : half_sel[15]);

  always_comb begin
    rdata_o = rdata_raw;
    if (rd_q) begin
      unique case (1'b1)
        sz_b:    rdata_o = {{24{ext}}, byte_sel};
        sz_h:    rdata_o = {{16{ext}}, half_sel};
        default: rdata_o = rdata_raw;
      endcase
    end
  end

  // Bubble to WB while the transfer is still in flight
  assign wb_ctrl_o = (stall_o | ~valid_q) ? '0 : wb_ctrl_q;
  assign pc_o      = pc_q;
  assign inst_o    = inst_q;
  assign ALUOut_o  = alu_q;
  assign db_dest_o = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a bus slave model,
// a write-back scoreboard, a bus-request scoreboard and stall-length checks.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] inst_i = '0;
  logic        valid_i = 1'b0;
  logic [4:0]  mem_ctrl_i = '0;
  logic [12:0] wb_ctrl_i = '0;
  logic [31:0] ALUOut_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  dest_i = '0;
  logic        stall_o;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        data_data_ok = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [12:0] wb_ctrl_o;
  logic [31:0] rdata_o;
  logic [31:0] ALUOut_o;
  logic [4:0]  db_dest_o;

  always #5 clk = ~clk;

  mem_stage #(.WB_CTRL_W(13)) dut (
    .clk(clk), .resetn(resetn),
    .pc_i(pc_i), .inst_i(inst_i), .valid_i(valid_i),
    .mem_ctrl_i(mem_ctrl_i), .wb_ctrl_i(wb_ctrl_i),
    .ALUOut_i(ALUOut_i), .wdata_i(wdata_i), .dest_i(dest_i),
    .stall_o(stall_o), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok),
    .pc_o(pc_o), .inst_o(inst_o), .wb_ctrl_o(wb_ctrl_o),
    .rdata_o(rdata_o), .ALUOut_o(ALUOut_o), .db_dest_o(db_dest_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [12:0] wb;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [31:0] rd;
    logic        chk;
  } wb_exp_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
  } bus_exp_t;

  wb_exp_t  wbq[$];
  bus_exp_t busq[$];
  int       stq[$];

  int applied = 0;
  int errs = 0;
  bit mon_en = 1'b0;

  int          cfg_a = 0;
  int          cfg_d = 0;
  logic [31:0] cfg_rdata = '0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Bus slave: addr_ok after cfg_a REQ cycles, data_ok cfg_d cycles later
  int sl_ph = 0;
  int sl_cnt = 0;
  bus_exp_t be;

  always @(negedge clk) begin
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h5A5A_5A5A;
    if (!resetn) begin
      sl_ph  = 0;
      sl_cnt = 0;
    end else if (sl_ph == 0) begin
      if (data_req) begin
        if (sl_cnt == cfg_a) begin
          data_addr_ok = 1'b1;
          sl_cnt = 0;
          if (mon_en) begin
            if (busq.size() == 0) begin
              check("bus_unexpected_req", {32'd0, data_addr}, 64'd0);
            end else begin
              be = busq.pop_front();
              check("bus_wr", {63'd0, data_wr}, {63'd0, be.wr});
              check("bus_size", {62'd0, data_size}, {62'd0, be.size});
              check("bus_addr", {32'd0, data_addr}, {32'd0, be.addr});
              check("bus_wstrb", {60'd0, data_wstrb}, {60'd0, be.strb});
              check("bus_wdata", {32'd0, data_wdata}, {32'd0, be.wd});
            end
          end
          if (cfg_d == 0) begin
            data_data_ok = 1'b1;
            data_rdata   = cfg_rdata;
          end else begin
            sl_ph = 1;
          end
        end else begin
          sl_cnt++;
        end
      end
    end else begin
      if (sl_cnt == cfg_d - 1) begin
        data_data_ok = 1'b1;
        data_rdata   = cfg_rdata;
        sl_ph  = 0;
        sl_cnt = 0;
      end else begin
        sl_cnt++;
      end
    end
  end

  // Write-back and stall monitor
  int      run = 0;
  wb_exp_t we;

  always @(negedge clk) begin
    if (mon_en && resetn) begin
      if (stall_o) begin
        run++;
        check("bubble_while_stalled", {51'd0, wb_ctrl_o}, 64'd0);
      end else begin
        if (run != 0) begin
          if (stq.size() == 0) check("stall_unexpected", run, 64'd0);
          else check("stall_cycles", run, stq.pop_front());
          run = 0;
        end
        if (wb_ctrl_o != '0) begin
          if (wbq.size() == 0) begin
            check("spurious_wb", {51'd0, wb_ctrl_o}, 64'd0);
          end else begin
            we = wbq.pop_front();
            check("wb_ctrl", {51'd0, wb_ctrl_o}, {51'd0, we.wb});
            check("pc", {32'd0, pc_o}, {32'd0, we.pc});
            check("inst", {32'd0, inst_o}, {32'd0, we.inst});
            check("aluout", {32'd0, ALUOut_o}, {32'd0, we.alu});
            check("dest", {59'd0, db_dest_o}, {59'd0, we.dest});
            if (we.chk) check("rdata", {32'd0, rdata_o}, {32'd0, we.rd});
          end
        end
      end
    end
  end

  task automatic issue(
    input logic [31:0] pc, input logic v, input logic [4:0] mc,
    input logic [12:0] wb, input logic [31:0] alu, input logic [31:0] wd,
    input logic [4:0] dest, input int a, input int d,
    input logic [31:0] brd, input logic [31:0] erd,
    input logic [3:0] estrb, input logic [31:0] ewd, input logic [1:0] esz
  );
    int n;
    bit is_mem;
    n = 0;
    @(negedge clk);
    while (stall_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      applied++;
      errs++;
      $display("FAIL stall_timeout: stall_o still %b after %0d cycles", stall_o, n);
    end
    pc_i       = pc;
    inst_i     = pc ^ 32'hA5A5_0000;
    valid_i    = v;
    mem_ctrl_i = mc;
    wb_ctrl_i  = wb;
    ALUOut_i   = alu;
    wdata_i    = wd;
    dest_i     = dest;
    cfg_a      = a;
    cfg_d      = d;
    cfg_rdata  = brd;
    is_mem     = v & (mc[0] | mc[1]);
    if (mon_en) begin
      if (v && wb != '0)
        wbq.push_back('{pc, pc ^ 32'hA5A5_0000, wb, alu, dest, erd,
                        mc[0] & ~mc[1]});
      if (is_mem) begin
        busq.push_back('{mc[1], esz, alu, estrb, ewd});
        stq.push_back(a + 1 + d);
      end
    end
    @(posedge clk);
  endtask

  task automatic bubble();
    issue(32'd0, 1'b0, 5'd0, 13'd0, 32'd0, 32'd0, 5'd0, 0, 0,
          32'd0, 32'd0, 4'd0, 32'd0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset dominates a memory op sitting on the inputs
    valid_i    = 1'b1;
    mem_ctrl_i = 5'b01001;
    wb_ctrl_i  = 13'h1FFF;
    pc_i       = 32'hFFFF_FFFF;
    ALUOut_i   = 32'hFFFF_FFFF;
    wdata_i    = 32'hFFFF_FFFF;
    dest_i     = 5'h1F;
    repeat (3) @(negedge clk);
    check("reset_stall_req", {62'd0, stall_o, data_req}, 64'd0);
    check("reset_wb_ctrl", {51'd0, wb_ctrl_o}, 64'd0);
    check("reset_pc_alu", {pc_o, ALUOut_o}, 64'd0);
    check("reset_inst_rdata", {inst_o, rdata_o}, 64'd0);
    check("reset_bus", {25'd0, data_wr, data_size, data_wstrb, data_addr}, 64'd0);
    check("reset_wdata_dest", {27'd0, data_wdata, db_dest_o}, 64'd0);
    valid_i = 1'b0;
    mem_ctrl_i = '0;
    wb_ctrl_i = '0;
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset", {50'd0, stall_o, wb_ctrl_o}, 64'd0);
    mon_en = 1'b1;

    //    pc        v  mem_ctrl  wb       alu            wdata          dst a  d  bus_rdata      exp_rdata      strb  exp_wdata      sz
    issue(32'h100, 1, 5'b00000, 13'h1,    32'h0000_1234, 32'h0,         5'd5, 0, 0, 32'h0,         32'h0,         4'h0, 32'h0,         2'd0);
    issue(32'h104, 1, 5'b00000, 13'h1FFD, 32'hFFFF_0000, 32'h0,         5'd6, 0, 0, 32'h0,         32'h0,         4'h0, 32'h0,         2'd0);
    // lb, both handshakes delayed
    issue(32'h108, 1, 5'b00001, 13'h3,    32'h0000_1003, 32'h0,         5'd7, 2, 2, 32'h8012_3456, 32'hFFFF_FF80, 4'h0, 32'h0,         2'd0);
    // lhu upper half
    issue(32'h10C, 1, 5'b10101, 13'h3,    32'h0000_2002, 32'h1122_3344, 5'd8, 1, 0, 32'hBEEF_0000, 32'h0000_BEEF, 4'h0, 32'h3344_3344, 2'd1);
    // lw, single-cycle handshake
    issue(32'h110, 1, 5'b01001, 13'h3,    32'h0000_4000, 32'hCAFE_BABE, 5'd9, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0, 32'hCAFE_BABE, 2'd2);
    // sb / sh / sw (read+write both set, size 3)
    issue(32'h114, 1, 5'b00010, 13'h100,  32'h0000_3001, 32'h0000_00AB, 5'd0, 0, 1, 32'h0,         32'h0,         4'h2, 32'hABAB_ABAB, 2'd0);
    issue(32'h118, 1, 5'b00110, 13'h100,  32'h0000_3002, 32'h0000_CAFE, 5'd0, 3, 0, 32'h0,         32'h0,         4'hC, 32'hCAFE_CAFE, 2'd1);
    issue(32'h11C, 1, 5'b01111, 13'h100,  32'h0000_3005, 32'h1234_5678, 5'd0, 1, 1, 32'h0,         32'h0,         4'hF, 32'h1234_5678, 2'd2);
    // lh lower half signed, lbu byte 2
    issue(32'h120, 1, 5'b00101, 13'h3,    32'h0000_5000, 32'h0,         5'd10, 0, 0, 32'h1234_8001, 32'hFFFF_8001, 4'h0, 32'h0,        2'd1);
    issue(32'h124, 1, 5'b10001, 13'h3,    32'h0000_6002, 32'h0000_005A, 5'd11, 0, 1, 32'h00C3_0000, 32'h0000_00C3, 4'h0, 32'h5A5A_5A5A, 2'd0);
    // invalid slot carrying memory control: no request, no write-back
    issue(32'h128, 0, 5'b00001, 13'h3,    32'h0000_7777, 32'h0,         5'd12, 0, 0, 32'h0,         32'h0,         4'h0, 32'h0,        2'd0);
    issue(32'h12C, 1, 5'b00000, 13'h1,    32'h0000_0042, 32'h0,         5'd13, 0, 0, 32'h0,         32'h0,         4'h0, 32'h0,        2'd0);
    // back-to-back lw/lw: second captured on the DONE edge
    issue(32'h130, 1, 5'b01001, 13'h3,    32'h0000_7000, 32'h0,         5'd14, 0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'h0, 32'h0,        2'd2);
    issue(32'h134, 1, 5'b01001, 13'h3,    32'h0000_7004, 32'h0,         5'd15, 0, 2, 32'h600D_CAFE, 32'h600D_CAFE, 4'h0, 32'h0,        2'd2);
    #1;
    check("b2b_no_idle_gap", {63'd0, data_req}, 64'd1);
    issue(32'h138, 1, 5'b00000, 13'h1,    32'h0000_0099, 32'h0,         5'd16, 0, 0, 32'h0,         32'h0,         4'h0, 32'h0,        2'd0);
    bubble();
    repeat (6) @(negedge clk);
    check("wbq_drained", wbq.size(), 64'd0);
    check("busq_drained", busq.size(), 64'd0);
    check("stq_drained", stq.size(), 64'd0);

    // Reset pulled during WAIT
    mon_en = 1'b0;
    issue(32'h200, 1, 5'b01001, 13'h3, 32'h0000_8000, 32'h0, 5'd17, 0, 10,
          32'h1111_1111, 32'h0, 4'h0, 32'h0, 2'd2);
    @(negedge clk);
    @(negedge clk);
    check("in_wait", {62'd0, stall_o, data_req}, 64'd2);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_wait_stall_req", {62'd0, stall_o, data_req}, 64'd0);
    check("rst_wait_wb", {51'd0, wb_ctrl_o}, 64'd0);
    check("rst_wait_pc_alu", {pc_o, ALUOut_o}, 64'd0);
    check("rst_wait_bus", {25'd0, data_wr, data_size, data_wstrb, data_addr}, 64'd0);
    valid_i = 1'b0;
    mem_ctrl_i = '0;
    wb_ctrl_i = '0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_wait_release", {62'd0, stall_o, data_req}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule
